// File: rtl/cache_ctrl_pkg.sv
// Shared types, address-field widths and byte lane helpers for the data cache miss controller.
package cache_ctrl_pkg;

  localparam int ADDR_W   = 32;
  localparam int SET_W    = 3;
  localparam int OFFSET_W = 2;
  localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_RD = 2'd1,
    ST_FILL   = 2'd2,
    ST_MEM_WR = 2'd3
  } state_t;

  function automatic logic [31:0] byte_extract(input logic [31:0] word,
                                               input logic [1:0]  offset);
    logic [7:0] b;
    case (offset)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {24'h0, b};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] word,
                                             input logic [7:0]  byte_v,
                                             input logic [1:0]  offset);
    logic [31:0] m;
    m = word;
    case (offset)
      2'd0:    m[7:0]   = byte_v;
      2'd1:    m[15:8]  = byte_v;
      2'd2:    m[23:16] = byte_v;
      default: m[31:24] = byte_v;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cache_miss_controller_lru.sv
// Per-set LRU bits for a 2-way cache; each bit names the way to evict next.
module cache_lru_table
  import cache_ctrl_pkg::*;
#(
  parameter int SET_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] rd_set,
  output logic             rd_way,
  input  logic             upd_en,
  input  logic [SET_W-1:0] upd_set,
  input  logic             upd_way
);

  localparam int NUM_SETS = 1 << SET_W;

  logic [NUM_SETS-1:0] lru_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lru_q <= '0;
    end else if (upd_en) begin
      lru_q[upd_set] <= ~upd_way;
    end
  end

  assign rd_way = lru_q[rd_set];

endmodule

// File: rtl/cache_miss_controller.sv
// Load/store sequencer for the 2-way write-through, no-write-allocate data cache.
// Optional hit/miss counters on loads when CACHE_PERF_CNT_EN is defined.
//   state     | meaning
//   ST_IDLE   | accept request; hits complete here
//   ST_MEM_RD | word fetch for a load miss
//   ST_FILL   | write fetched word to victim way, return load data
//   ST_MEM_WR | write-through of a store to memory
module cache_miss_controller
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SET_W    = 3,
  parameter int NUM_WAYS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cpu_req_i,
  input  logic                      cpu_we_i,
  input  logic                      cpu_byte_i,
  input  logic [ADDR_W-1:0]         cpu_addr_i,
  input  logic [DATA_W-1:0]         cpu_wdata_i,
  output logic [DATA_W-1:0]         cpu_rdata_o,
  output logic                      cpu_done_o,
  output logic                      cpu_stall_o,
  output logic [SET_W-1:0]          cache_set_o,
  output logic [ADDR_W-SET_W-3:0]   cache_tag_o,
  input  logic                      cache_hit_i,
  input  logic                      cache_hit_way_i,
  input  logic [DATA_W-1:0]         cache_rdata_i,
  output logic                      cache_fill_o,
  output logic                      cache_fill_way_o,
  output logic [DATA_W-1:0]         cache_fill_data_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic                      mem_byte_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]               hit_count_o,
  output logic [31:0]               miss_count_o,
`endif
  input  logic                      mem_ready_i
);

  localparam int WAY_W = $clog2(NUM_WAYS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                byte_q;
  logic [WAY_W-1:0]    victim_q;

  logic [ADDR_W-1:0]   cur_addr;
  logic [SET_W-1:0]    cur_set;
  logic [1:0]          cur_off;
  logic                lru_rd_way;
  logic                lru_en;
  logic                lru_way;

  // Once the access leaves IDLE the pipeline is frozen, so the latched address drives the array.
  assign cur_addr    = (state_q == ST_IDLE) ? cpu_addr_i : addr_q;
  assign cur_set     = cur_addr[SET_W+1:2];
  assign cur_off     = cur_addr[1:0];
  assign cache_set_o = cur_set;
  assign cache_tag_o = cur_addr[ADDR_W-1:SET_W+2];

  cache_lru_table #(.SET_W(SET_W)) u_lru (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_set  (cur_set),
    .rd_way  (lru_rd_way),
    .upd_en  (lru_en),
    .upd_set (cur_set),
    .upd_way (lru_way)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (cpu_we_i)          state_d = ST_MEM_WR;
          else if (!cache_hit_i) state_d = ST_MEM_RD;
        end
      end
      ST_MEM_RD: if (mem_ready_i) state_d = ST_FILL;
      ST_FILL:   state_d = ST_IDLE;
      ST_MEM_WR: if (mem_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_rdata_o       = '0;
    cpu_done_o        = 1'b0;
    cpu_stall_o       = 1'b0;
    cache_fill_o      = 1'b0;
    cache_fill_way_o  = 1'b0;
    cache_fill_data_o = '0;
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_byte_o        = 1'b0;
    mem_addr_o        = '0;
    mem_wdata_o       = '0;
    lru_en            = 1'b0;
    lru_way           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          if (cpu_we_i) begin
            cpu_stall_o = 1'b1;
            if (cache_hit_i) begin
              cache_fill_o      = 1'b1;
              cache_fill_way_o  = cache_hit_way_i;
              cache_fill_data_o = cpu_byte_i ?
                                  byte_merge(cache_rdata_i, cpu_wdata_i[7:0], cur_off) :
                                  cpu_wdata_i;
              lru_en            = 1'b1;
              lru_way           = cache_hit_way_i;
            end
          end else if (cache_hit_i) begin
            cpu_done_o  = 1'b1;
            cpu_rdata_o = cpu_byte_i ? byte_extract(cache_rdata_i, cur_off) : cache_rdata_i;
            lru_en      = 1'b1;
            lru_way     = cache_hit_way_i;
          end else begin
            cpu_stall_o = 1'b1;
          end
        end
      end
      ST_MEM_RD: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
      end
      ST_FILL: begin
        cache_fill_o      = 1'b1;
        cache_fill_way_o  = victim_q;
        cache_fill_data_o = rdata_q;
        cpu_done_o        = 1'b1;
        cpu_rdata_o       = byte_q ? byte_extract(rdata_q, cur_off) : rdata_q;
        lru_en            = 1'b1;
        lru_way           = victim_q;
      end
      ST_MEM_WR: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_byte_o  = byte_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        cpu_done_o  = mem_ready_i;
        cpu_stall_o = ~mem_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      byte_q   <= 1'b0;
      victim_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cpu_req_i && (cpu_we_i || !cache_hit_i)) begin
        addr_q   <= cpu_addr_i;
        byte_q   <= cpu_byte_i;
        wdata_q  <= cpu_wdata_i;
        victim_q <= lru_rd_way;
      end
      if (state_q == ST_MEM_RD && mem_ready_i) begin
        rdata_q <= mem_rdata_i;
      end
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic idle_load;
  assign idle_load = (state_q == ST_IDLE) && cpu_req_i && !cpu_we_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else if (idle_load) begin
      if (cache_hit_i && hit_count_o != 32'hFFFF_FFFF)
        hit_count_o <= hit_count_o + 32'd1;
      if (!cache_hit_i && miss_count_o != 32'hFFFF_FFFF)
        miss_count_o <= miss_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed self-checking bench for cache_miss_controller; counter checks with CACHE_PERF_CNT_EN.
module tb_cache_miss_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_i, cpu_we_i, cpu_byte_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic        cpu_done_o, cpu_stall_o;
  logic [2:0]  cache_set_o;
  logic [26:0] cache_tag_o;
  logic        cache_hit_i, cache_hit_way_i;
  logic [31:0] cache_rdata_i;
  logic        cache_fill_o, cache_fill_way_o;
  logic [31:0] cache_fill_data_o;
  logic        mem_req_o, mem_we_o, mem_byte_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_ready_i;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count_o, miss_count_o;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  cache_miss_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_byte_i(cpu_byte_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_done_o(cpu_done_o), .cpu_stall_o(cpu_stall_o),
    .cache_set_o(cache_set_o), .cache_tag_o(cache_tag_o),
    .cache_hit_i(cache_hit_i), .cache_hit_way_i(cache_hit_way_i), .cache_rdata_i(cache_rdata_i),
    .cache_fill_o(cache_fill_o), .cache_fill_way_o(cache_fill_way_o),
    .cache_fill_data_o(cache_fill_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_byte_o(mem_byte_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
`ifdef CACHE_PERF_CNT_EN
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
`endif
    .mem_ready_i(mem_ready_i)
  );

  task automatic chk(input string step, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s/%s observed=%h expected=%h", step, what, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic byt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hit, input logic hway,
                       input logic [31:0] crd);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_byte_i = byt; cpu_addr_i = addr;
    cpu_wdata_i = wdata; cache_hit_i = hit; cache_hit_way_i = hway; cache_rdata_i = crd;
  endtask

  task automatic idle_inputs();
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_byte_i = 1'b0; cpu_addr_i = '0;
    cpu_wdata_i = '0; cache_hit_i = 1'b0; cache_hit_way_i = 1'b0; cache_rdata_i = '0;
  endtask

  task automatic load_hit(input string s, input logic byt, input logic [31:0] addr,
                          input logic hway, input logic [31:0] crd, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b0, byt, addr, 32'h0, 1'b1, hway, crd);
    #1;
    chk(s, "done", cpu_done_o, 1);
    chk(s, "rdata", cpu_rdata_o, exp);
    chk(s, "stall", cpu_stall_o, 0);
    chk(s, "mem_req", mem_req_o, 0);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic load_miss(input string s, input logic byt, input logic [31:0] addr,
                           input logic [31:0] word, input int waits,
                           input logic exp_way, input logic [31:0] exp_rd);
    @(negedge clk);
    drive(1'b0, byt, addr, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_ready_i = 1'b0;
    #1;
    chk(s, "issue_stall", cpu_stall_o, 1);
    chk(s, "issue_done", cpu_done_o, 0);
    chk(s, "issue_tag", cache_tag_o, addr[31:5]);
    @(negedge clk);
    cpu_addr_i = ~addr; cpu_byte_i = ~byt; cache_hit_i = 1'b1;
    #1;
    for (int i = 0; i < waits; i++) begin
      chk(s, "wait_req", mem_req_o, 1);
      chk(s, "wait_stall", cpu_stall_o, 1);
      @(negedge clk);
      #1;
    end
    mem_ready_i = 1'b1; mem_rdata_i = word;
    #1;
    chk(s, "rd_req", mem_req_o, 1);
    chk(s, "rd_we", mem_we_o, 0);
    chk(s, "rd_addr", mem_addr_o, {addr[31:2], 2'b00});
    chk(s, "rd_set", cache_set_o, addr[4:2]);
    @(negedge clk);
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    #1;
    chk(s, "fill", cache_fill_o, 1);
    chk(s, "fill_way", cache_fill_way_o, exp_way);
    chk(s, "fill_data", cache_fill_data_o, word);
    chk(s, "fill_set", cache_set_o, addr[4:2]);
    chk(s, "done", cpu_done_o, 1);
    chk(s, "rdata", cpu_rdata_o, exp_rd);
    chk(s, "stall", cpu_stall_o, 0);
    chk(s, "mem_req_off", mem_req_o, 0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk(s, "after_done", cpu_done_o, 0);
  endtask

  task automatic store(input string s, input logic byt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic hit, input logic hway,
                       input logic [31:0] crd, input int waits, input logic [31:0] exp_fill);
    @(negedge clk);
    drive(1'b1, byt, addr, wdata, hit, hway, crd);
    mem_ready_i = 1'b0;
    #1;
    chk(s, "issue_stall", cpu_stall_o, 1);
    chk(s, "issue_done", cpu_done_o, 0);
    chk(s, "issue_fill", cache_fill_o, hit);
    if (hit) begin
      chk(s, "fill_way", cache_fill_way_o, hway);
      chk(s, "fill_data", cache_fill_data_o, exp_fill);
    end
    @(negedge clk);
    drive(1'b1, ~byt, ~addr, ~wdata, 1'b0, 1'b0, 32'h0);
    #1;
    for (int i = 0; i < waits; i++) begin
      chk(s, "wait_stall", cpu_stall_o, 1);
      chk(s, "wait_done", cpu_done_o, 0);
      @(negedge clk);
      #1;
    end
    mem_ready_i = 1'b1;
    #1;
    chk(s, "wr_req", mem_req_o, 1);
    chk(s, "wr_we", mem_we_o, 1);
    chk(s, "wr_byte", mem_byte_o, byt);
    chk(s, "wr_addr", mem_addr_o, addr);
    chk(s, "wr_data", mem_wdata_o, wdata);
    chk(s, "wr_fill", cache_fill_o, 0);
    chk(s, "done", cpu_done_o, 1);
    chk(s, "stall", cpu_stall_o, 0);
    @(negedge clk);
    mem_ready_i = 1'b0;
    idle_inputs();
    #1;
    chk(s, "after_req", mem_req_o, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    #3;
    chk("reset", "done", cpu_done_o, 0);
    chk("reset", "stall", cpu_stall_o, 0);
    chk("reset", "mem_req", mem_req_o, 0);
    chk("reset", "fill", cache_fill_o, 0);
    chk("reset", "mem_addr", mem_addr_o, 0);
    chk("reset", "rdata", cpu_rdata_o, 0);
`ifdef CACHE_PERF_CNT_EN
    chk("reset", "hits", hit_count_o, 0);
    chk("reset", "misses", miss_count_o, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    load_miss("lw_miss_w0", 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF);
    load_hit("lw_hit", 1'b0, 32'h0001_0004, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_hit("lbu_hit", 1'b1, 32'h0001_0006, 1'b0, 32'hDEAD_BEEF, 32'h0000_00AD);
    load_miss("lw_miss_w1", 1'b0, 32'h0001_0024, 32'hDEAD_BEEF, 0, 1'b1, 32'hDEAD_BEEF);
    load_miss("lw_evict_w0", 1'b0, 32'h0001_0044, 32'h0BAD_F00D, 1, 1'b0, 32'h0BAD_F00D);
    store("sb_hit", 1'b1, 32'h0001_0025, 32'hAAAA_AA77, 1'b1, 1'b1, 32'hDEAD_BEEF, 1,
          32'hDEAD_77EF);
    store("sw_miss", 1'b0, 32'h0002_0000, 32'h55AA_55AA, 1'b0, 1'b0, 32'h0, 0, 32'h0);
`ifdef CACHE_PERF_CNT_EN
    chk("perf", "hits", hit_count_o, 2);
    chk("perf", "misses", miss_count_o, 3);
`endif
    load_miss("lbu_miss", 1'b1, 32'h0001_0063, 32'h1122_3344, 2, 1'b0, 32'h0000_0011);
    load_miss("lw_after_sb", 1'b0, 32'h0001_0084, 32'h8484_8484, 0, 1'b0, 32'h8484_8484);

    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0001_0104, 32'h0, 1'b0, 1'b0, 32'h0);
    #1;
    @(negedge clk);
    #1;
    chk("rst_mid", "req_before", mem_req_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", "req_dropped", mem_req_o, 0);
    chk("rst_mid", "no_fill", cache_fill_o, 0);
    chk("rst_mid", "no_done", cpu_done_o, 0);
    idle_inputs();
    #1;
    chk("rst_mid", "stall", cpu_stall_o, 0);
`ifdef CACHE_PERF_CNT_EN
    chk("rst_mid", "hits", hit_count_o, 0);
    chk("rst_mid", "misses", miss_count_o, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    load_miss("post_rst_lru", 1'b0, 32'h0001_0004, 32'hCAFE_F00D, 0, 1'b0, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
